// File: rtl/regfile_param.sv
// Parameterised register file with one-cycle registered reads, optional write bypass,
// per-register busy scoreboard and a sequential clear engine.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int DBG_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] rsdata,
  output logic [DATA_W-1:0] rtdata,
  input  logic [ADDR_W-1:0] writeaddr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              regwrite,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic [ADDR_W-1:0] index,
  output logic [DBG_W-1:0]  number
);

  // state | meaning
  // IDLE  | normal read/write/scoreboard operation
  // CLEAR | zeroing one register per cycle, write port and mark ignored
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              idle;
  logic              wr_ok;
  logic              mark_ok;
  logic [DATA_W-1:0] rs_next;
  logic [DATA_W-1:0] rt_next;

  assign idle    = (state == IDLE);
  assign wr_ok   = regwrite && idle && !((ZERO_REG != 0) && (writeaddr == '0));
  assign mark_ok = mark_en && !((ZERO_REG != 0) && (mark_addr == '0));

  // The read mux sees the forwarded write only when the write will actually land.
  always_comb begin
    rs_next = regs[rs];
    rt_next = regs[rt];
    if ((BYPASS != 0) && wr_ok && (writeaddr == rs)) rs_next = writedata;
    if ((BYPASS != 0) && wr_ok && (writeaddr == rt)) rt_next = writedata;
    if ((ZERO_REG != 0) && (rs == '0)) rs_next = '0;
    if ((ZERO_REG != 0) && (rt == '0)) rt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_ptr <= '0;
      rsdata  <= '0;
      rtdata  <= '0;
      busy    <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      rsdata <= rs_next;
      rtdata <= rt_next;
      if (state == CLEAR) begin
        regs[clr_ptr] <= '0;
        busy[clr_ptr] <= 1'b0;
        if (clr_ptr == LAST_ADDR) state <= IDLE;
        else clr_ptr <= clr_ptr + 1'b1;
      end else begin
        if (wr_ok) begin
          regs[writeaddr] <= writedata;
          busy[writeaddr] <= 1'b0;
        end
        // Placed after the write-clear so a same-edge mark wins.
        if (mark_ok) busy[mark_addr] <= 1'b1;
        if (clear_req) begin
          state   <= CLEAR;
          clr_ptr <= '0;
        end
      end
    end
  end

  assign rs_busy    = busy[rs] && !((BYPASS != 0) && regwrite && idle && (writeaddr == rs));
  assign rt_busy    = busy[rt] && !((BYPASS != 0) && regwrite && idle && (writeaddr == rt));
  assign clear_busy = (state == CLEAR);

  always_comb begin
    number = regs[index][DBG_W-1:0];
    if ((ZERO_REG != 0) && (index == '0)) number = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param: a default instance and a
// 16-bit/8-entry instance without bypass.
module tb_regfile_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  a_rs, a_rt, a_waddr, a_maddr, a_index;
  logic [31:0] a_rsdata, a_rtdata, a_wdata;
  logic        a_we, a_mark, a_rs_busy, a_rt_busy, a_clr, a_clr_busy;
  logic [15:0] a_number;

  logic [2:0]  b_rs, b_rt, b_waddr, b_maddr, b_index;
  logic [15:0] b_rsdata, b_rtdata, b_wdata;
  logic        b_we, b_mark, b_rs_busy, b_rt_busy, b_clr, b_clr_busy;
  logic [15:0] b_number;

  int checks = 0;
  int errors = 0;
  int n;

  regfile_param u_dut (
    .clk(clk), .rst_n(rst_n), .rs(a_rs), .rt(a_rt), .rsdata(a_rsdata), .rtdata(a_rtdata),
    .writeaddr(a_waddr), .writedata(a_wdata), .regwrite(a_we), .mark_en(a_mark),
    .mark_addr(a_maddr), .rs_busy(a_rs_busy), .rt_busy(a_rt_busy), .clear_req(a_clr),
    .clear_busy(a_clr_busy), .index(a_index), .number(a_number)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) u_small (
    .clk(clk), .rst_n(rst_n), .rs(b_rs), .rt(b_rt), .rsdata(b_rsdata), .rtdata(b_rtdata),
    .writeaddr(b_waddr), .writedata(b_wdata), .regwrite(b_we), .mark_en(b_mark),
    .mark_addr(b_maddr), .rs_busy(b_rs_busy), .rt_busy(b_rt_busy), .clear_req(b_clr),
    .clear_busy(b_clr_busy), .index(b_index), .number(b_number)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [4:0] addr, input logic [31:0] data);
    a_we = 1'b1; a_waddr = addr; a_wdata = data;
    tick();
    a_we = 1'b0;
  endtask

  initial begin
    a_rs = '0; a_rt = '0; a_waddr = '0; a_maddr = '0; a_index = '0; a_wdata = '0;
    a_we = 1'b0; a_mark = 1'b0; a_clr = 1'b0;
    b_rs = '0; b_rt = '0; b_waddr = '0; b_maddr = '0; b_index = '0; b_wdata = '0;
    b_we = 1'b0; b_mark = 1'b0; b_clr = 1'b0;

    #12;
    chk("reset_rsdata", a_rsdata, 32'h0);
    chk("reset_rtdata", a_rtdata, 32'h0);
    chk("reset_clear_busy", {31'b0, a_clr_busy}, 32'h0);
    chk("reset_small_rsdata", {16'b0, b_rsdata}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic write then read with one-cycle latency
    a_write(5'd5, 32'hDEADBEEF);
    a_rs = 5'd5;
    tick();
    chk("read_r5", a_rsdata, 32'hDEADBEEF);

    a_write(5'd0, 32'h11111111);
    a_rs = 5'd0; a_index = 5'd0;
    tick();
    chk("read_r0", a_rsdata, 32'h0);
    chk("dbg_r0", {16'b0, a_number}, 32'h0);

    // same-edge write forwards to rt
    a_write(5'd7, 32'h0000AAAA);
    a_rt = 5'd7;
    a_write(5'd7, 32'h12345678);
    chk("bypass_rt7", a_rtdata, 32'h12345678);
    tick();
    chk("stored_rt7", a_rtdata, 32'h12345678);

    // scoreboard
    a_mark = 1'b1; a_maddr = 5'd3;
    tick();
    a_mark = 1'b0; a_rs = 5'd3; a_rt = 5'd3;
    #1;
    chk("busy_rs3_set", {31'b0, a_rs_busy}, 32'h1);
    chk("busy_rt3_set", {31'b0, a_rt_busy}, 32'h1);
    a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h33;
    #1;
    chk("busy_rs3_fwd", {31'b0, a_rs_busy}, 32'h0);
    tick();
    a_we = 1'b0;
    #1;
    chk("busy_rs3_clr", {31'b0, a_rs_busy}, 32'h0);
    a_mark = 1'b1; a_maddr = 5'd3; a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h44;
    tick();
    a_mark = 1'b0; a_we = 1'b0;
    #1;
    chk("busy_set_wins", {31'b0, a_rs_busy}, 32'h1);
    a_mark = 1'b1; a_maddr = 5'd0;
    tick();
    a_mark = 1'b0; a_rs = 5'd0;
    #1;
    chk("busy_r0", {31'b0, a_rs_busy}, 32'h0);

    // fill, then sequential clear with ignored writes/marks
    for (int i = 1; i < 32; i++) a_write(5'(i), 32'h10000000 + i);
    a_rs = 5'd31; a_index = 5'd31;
    tick();
    chk("fill_r31", a_rsdata, 32'h1000001F);
    chk("fill_dbg31", {16'b0, a_number}, 32'h001F);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'hFFFF; a_mark = 1'b1; a_maddr = 5'd4;
    n = 0;
    while (a_clr_busy && n < 100) begin
      n++;
      tick();
    end
    a_we = 1'b0; a_mark = 1'b0;
    chk("clear_len32", n, 32);
    for (int i = 0; i < 32; i++) begin
      a_rs = 5'(i); a_rt = 5'(31 - i); a_index = 5'(i);
      tick();
      if (a_rsdata != 0 || a_rtdata != 0 || a_number != 0 || a_rs_busy) begin
        chk($sformatf("post_clear_r%0d", i), a_rsdata | a_rtdata | {16'b0, a_number} | {31'b0, a_rs_busy}, 32'h0);
      end
    end
    a_rs = 5'd4;
    #1;
    chk("post_clear_busy4", {31'b0, a_rs_busy}, 32'h0);
    a_rs = 5'd9;
    tick();
    chk("post_clear_r9", a_rsdata, 32'h0);

    // reset at clear cycle 10
    a_write(5'd20, 32'h00002020);
    a_rs = 5'd20; a_index = 5'd20;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("midclear_busy", {31'b0, a_clr_busy}, 32'h1);
    chk("midclear_r20", a_rsdata, 32'h00002020);
    rst_n = 1'b0;
    #1;
    chk("abort_clear_busy", {31'b0, a_clr_busy}, 32'h0);
    chk("abort_rsdata", a_rsdata, 32'h0);
    chk("abort_number", {16'b0, a_number}, 32'h0);
    tick();
    rst_n = 1'b1;
    a_write(5'd9, 32'h00000099);
    a_rs = 5'd9;
    tick();
    chk("after_abort_r9", a_rsdata, 32'h00000099);
    chk("after_abort_idle", {31'b0, a_clr_busy}, 32'h0);

    // small instance, no bypass
    b_we = 1'b1; b_waddr = 3'd7; b_wdata = 16'hFFFF;
    tick();
    b_we = 1'b0; b_index = 3'd7;
    #1;
    chk("small_dbg7", {16'b0, b_number}, 32'h0000FFFF);
    b_we = 1'b1; b_waddr = 3'd7; b_wdata = 16'h5678; b_rt = 3'd7;
    tick();
    b_we = 1'b0;
    chk("small_nobypass_old", {16'b0, b_rtdata}, 32'h0000FFFF);
    tick();
    chk("small_new", {16'b0, b_rtdata}, 32'h00005678);
    b_mark = 1'b1; b_maddr = 3'd2;
    tick();
    b_mark = 1'b0; b_rs = 3'd2; b_we = 1'b1; b_waddr = 3'd2; b_wdata = 16'h0002;
    #1;
    chk("small_busy_noforce", {31'b0, b_rs_busy}, 32'h1);
    tick();
    b_we = 1'b0;
    #1;
    chk("small_busy_clr", {31'b0, b_rs_busy}, 32'h0);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    n = 0;
    while (b_clr_busy && n < 100) begin
      n++;
      tick();
    end
    chk("small_clear_len8", n, 8);
    #1;
    chk("small_post_clear_dbg7", {16'b0, b_number}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1: when 1, register 0 reads 0 and ignores writes.
REQ-004 The block SHALL have parameter BYPASS, default 1: when 1, a same-cycle write forwards to the read ports.
REQ-005 The block SHALL have parameter DBG_W, default 16: debug output width, with DBG_W <= DATA_W.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have ports rs and rt, input, ADDR_W bits each: read addresses.
REQ-009 The block SHALL have ports rsdata and rtdata, output, DATA_W bits each: registered read data.
REQ-010 The block SHALL have ports writeaddr (ADDR_W), writedata (DATA_W) and regwrite (1), all inputs: the write port.
REQ-011 The block SHALL have ports mark_en (1) and mark_addr (ADDR_W), inputs: scoreboard set request.
REQ-012 The block SHALL have ports rs_busy and rt_busy, output, 1 bit each: pending-write flags for rs and rt.
REQ-013 The block SHALL have port clear_req, input, 1 bit: request to start a sequential clear.
REQ-014 The block SHALL have port clear_busy, output, 1 bit: high while a clear is in progress.
REQ-015 The block SHALL have port index, input, ADDR_W bits, and port number, output, DBG_W bits: debug read, number = register[index][DBG_W-1:0], combinational.

Function
REQ-016 Writes SHALL occur only on the rising clk edge, only when regwrite=1 and the state is IDLE; when ZERO_REG=1, writes to address 0 SHALL be dropped.
REQ-017 On each rising edge, rsdata SHALL load register[rs] and rtdata SHALL load register[rt], giving one-cycle read latency.
REQ-018 With BYPASS=1, a valid same-edge write to the address being read (rs or rt) SHALL load writedata into that read output; with BYPASS=0, the read output SHALL load the old value.
REQ-019 With ZERO_REG=1, reads of address 0 SHALL return 0 and the debug read of index=0 SHALL return 0, regardless of the write port.
REQ-020 Each register SHALL have a busy bit: mark_en=1 sets busy[mark_addr]; a valid write clears busy[writeaddr]; if both target the same address on the same edge, set SHALL win.
REQ-021 With ZERO_REG=1, busy[0] SHALL remain 0.
REQ-022 rs_busy SHALL equal busy[rs], combinational; with BYPASS=1 it SHALL be forced to 0 when regwrite=1 and writeaddr==rs in IDLE. rt_busy SHALL follow the same rule using rt.
REQ-023 The block SHALL implement a state machine with two states, IDLE and CLEAR.
REQ-024 In IDLE, clear_req=1 SHALL move the state to CLEAR on the next edge and load clr_ptr=0.
REQ-025 In CLEAR, each edge SHALL write 0 to register[clr_ptr], clear busy[clr_ptr], and increment clr_ptr.
REQ-026 In CLEAR, when clr_ptr==DEPTH-1, the state SHALL return to IDLE after that write; a clear SHALL last exactly DEPTH cycles.
REQ-027 In CLEAR, regwrite, mark_en and clear_req SHALL be ignored, and read outputs SHALL continue to register current contents.
REQ-028 clear_busy SHALL be 1 exactly while the state is CLEAR.
REQ-029 clr_ptr SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH-1 within a clear.

Reset
REQ-030 When rst_n=0, asynchronously, all registers SHALL be 0, all busy bits SHALL be 0, rsdata and rtdata SHALL be 0, the state SHALL be IDLE and clr_ptr SHALL be 0.
REQ-031 Reset asserted mid-clear SHALL abort the clear; the block SHALL be IDLE after release.
REQ-032 After rst_n rises, the first rising edge SHALL operate normally.

Verification
REQ-033 Write 0xDEADBEEF to r5, then rs=5 on the next edge -> rsdata=0xDEADBEEF one cycle later; a write to r0 -> rs=0 reads 0.
REQ-034 BYPASS=1: regwrite to r7 with 0x12345678 while rt=7 on the same edge -> rtdata=0x12345678 after that edge; BYPASS=0 -> the old value.
REQ-035 mark_en r3 -> rs=3 gives rs_busy=1; write r3 -> rs_busy=0 after the edge; mark_en and write to r3 on the same edge -> busy remains 1.
REQ-036 Fill all registers with nonzero values, pulse clear_req -> clear_busy high for 32 cycles (DEPTH=32); writes during the clear are ignored; afterwards all reads and number return 0.
REQ-037 Drop rst_n at clear cycle 10 -> immediate zero outputs, clear_busy=0; after release, a write to r9 succeeds.
REQ-038 DATA_W=16, ADDR_W=3 instance -> a clear lasts 8 cycles; write 0xFFFF to r7 -> index=7 gives number=0xFFFF.
